unpack_unsigned_stream: RTL and testbench
=========================================

UNPACK_UNSIGNED_STREAM -- requirements
Module: unpack_unsigned_stream

Interface
REQ-001 SHALL have parameter N, default 64: decoded width in bits; MB = N/7+1 is the maximum bytes per value; LW = $clog2(MB).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_data, input, 8: LEB128 byte; bit7 is the continuation (glue) bit, bits6:0 are data.
REQ-005 SHALL have port in_valid, input, 1: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1: the block accepts the byte this cycle.
REQ-007 SHALL have port out_data, output, N: decoded unsigned value.
REQ-008 SHALL have port out_len, output, LW: byte count minus 1 of the decoded value.
REQ-009 SHALL have port out_err, output, 1: the value is overlong or overflows N.
REQ-010 SHALL have port out_valid, output, 1: out_data, out_len and out_err are valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts the output.

Function
REQ-012 SHALL treat a byte as accepted when in_valid and in_ready are both 1 in the same cycle; likewise, an output is taken when out_valid and out_ready are both 1.
REQ-013 SHALL implement states COLLECT, EMIT and DRAIN; in_ready = 1 in COLLECT and DRAIN, and 0 in EMIT.
REQ-014 In COLLECT, each accepted byte SHALL be written to buffer slot cnt (0..MB-1), after which cnt increments.
REQ-015 In COLLECT, an accepted byte with bit7=0 SHALL terminate the value: transition to EMIT with err = (byte overflow per REQ-018).
REQ-016 In COLLECT, an accepted byte at cnt = MB-1 with bit7=1 SHALL transition to EMIT with err = 1 (overlong).
REQ-017 In EMIT, out_valid = 1, with out_data and out_len taken from the combinational unpack of the buffer; outputs SHALL be held stable until taken.
REQ-018 Overflow: if the value terminates at slot MB-1 and any data bit of that byte maps to weight >= 2^N, err SHALL be 1; out_data keeps the truncated low N bits.
REQ-019 On output taken: from non-overlong EMIT, go to COLLECT with cnt = 0 and the buffer cleared; from overlong EMIT, go to DRAIN.
REQ-020 DRAIN SHALL accept and discard bytes; an accepted byte with bit7=0 returns the block to COLLECT with cnt = 0.
REQ-021 Latency: out_valid SHALL rise in the cycle after the terminating (or MB-th) byte is accepted; throughput is one byte per cycle plus at least one EMIT cycle per value.
REQ-022 out_len SHALL equal cnt at termination (0 for 1-byte values; MB-1 at maximum length).
REQ-023 in_valid low mid-value SHALL stall collection without losing state; there is no timeout.

Reset
REQ-024 While rst = 1 at a clock edge: state = COLLECT, cnt = 0, buffer = 0, out_valid = 0, out_data = 0, out_len = 0, out_err = 0; in_ready SHALL be 0 during reset.
REQ-025 Reset mid-value or during EMIT/DRAIN SHALL discard partial and pending results; the first byte accepted after reset starts a new value.

Structure
REQ-026 Shared package SHALL hold the state enum (COLLECT/EMIT/DRAIN) and the MB/LW derivation functions of N.
REQ-027 SHALL instantiate unpack_unsigned #(.N(N)) as the single sub-module, fed from the MB*8-bit buffer with slot 0 in the leading byte position; it provides out_data and out_len directly.
REQ-028 Registers SHALL be limited to the buffer, cnt, state and err; the RTL target is 120-400 lines.

Verification
REQ-029 Bytes 0x00 -> out_data = 0, out_len = 0, out_err = 0, out_valid one cycle after acceptance.
REQ-030 Bytes 0xE5 0x8E 0x26 -> out_data = 624485 (0x98765), out_len = 2, out_err = 0.
REQ-031 Bytes 0xFF x9, then 0x01 -> out_data = 2^64-1, out_len = 9, out_err = 0; with final byte 0x03 instead of 0x01 -> same data, out_err = 1.
REQ-032 Bytes 0x80 x10, then 0x80 0x00, then 0x05 -> EMIT after the 10th byte with out_err = 1, len = 9, data = 0; the next two bytes are discarded in DRAIN; the next output is data = 5, len = 0.
REQ-033 Backpressure: value 0x7F with out_ready = 0 for 5 cycles -> in_ready = 0 and outputs stable throughout; the output is taken on the 6th cycle; the next byte is accepted the following cycle.
REQ-034 Reset asserted after bytes 0x81 0x82 -> all outputs zero; byte 0x03 then yields data = 3, len = 0.

Source files
------------

// File: rtl/unpack_unsigned_stream_pkg.sv
// Shared definitions for the unsigned LEB128 stream decoder: FSM states and
// the derivation of buffer depth and length width from the decoded width N.
package unpack_unsigned_stream_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Maximum number of LEB128 bytes that can carry an N-bit value.
    function automatic int calcMb(input int n);
        return n / 7 + 1;
    endfunction

    // Width needed to express a byte count minus one.
    function automatic int calcLw(input int n);
        return $clog2(calcMb(n));
    endfunction

    // Lowest data bit of the last possible byte whose weight reaches 2^N.
    function automatic int calcOvfLsb(input int n);
        return n - 7 * (calcMb(n) - 1);
    endfunction

endpackage

// File: rtl/unpack_unsigned_stream_unpack.sv
// Combinational LEB128 unpacker: slot 0 sits in the most significant byte of
// i_data. The value ends at the first slot with a clear continuation bit, or
// at the last slot if none is clear; data bits beyond N are dropped.
module unpack_unsigned
    import unpack_unsigned_stream_pkg::*;
#(
    parameter int N  = 64,
    parameter int MB = calcMb(N),
    parameter int LW = calcLw(N)
) (
    input  logic [MB*8-1:0] i_data,
    output logic [N-1:0]    o_data,
    output logic [LW-1:0]   o_len
);

    logic w_found;

    // Accumulate 7-bit groups up to and including the terminating slot.
    always_comb begin
        o_data  = '0;
        o_len   = LW'(MB - 1);
        w_found = 1'b0;
        for (int i = 0; i < MB; i++) begin
            if (!w_found) begin
                o_data = o_data | (N'(i_data[(MB-1-i)*8 +: 7]) << (7 * i));
                if (!i_data[(MB-1-i)*8 + 7]) begin
                    o_len   = LW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/unpack_unsigned_stream.sv
// Streaming unsigned LEB128 decoder. Bytes are collected into a slot buffer,
// the finished value is presented until taken, and overlong values cause the
// rest of the offending byte run to be drained.
module unpack_unsigned_stream
    import unpack_unsigned_stream_pkg::*;
#(
    parameter int N  = 64,
    parameter int MB = calcMb(N),
    parameter int LW = calcLw(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [N-1:0]  out_data,
    output logic [LW-1:0] out_len,
    output logic          out_err,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int OVF_LSB = calcOvfLsb(N);

    state_t                r_state;
    logic [LW-1:0]         r_cnt;
    logic [0:MB-1][7:0]    r_buf;
    logic                  r_err;

    logic                  w_inTake;
    logic                  w_outTake;
    logic                  w_lastSlot;
    logic                  w_overflow;
    logic                  w_overlong;
    logic [MB*8-1:0]       w_flat;
    logic [N-1:0]          w_data;
    logic [LW-1:0]         w_len;

    assign in_ready   = !rst && (r_state != EMIT);
    assign out_valid  = (r_state == EMIT);
    assign w_inTake   = in_valid && in_ready;
    assign w_outTake  = out_valid && out_ready;
    assign w_lastSlot = (r_cnt == LW'(MB - 1));
    assign w_overflow = |(in_data[6:0] >> OVF_LSB);
    assign w_overlong = r_buf[MB-1][7];
    assign w_flat     = r_buf;

    assign out_data = out_valid ? w_data : '0;
    assign out_len  = out_valid ? w_len : '0;
    assign out_err  = r_err;

    unpack_unsigned #(
        .N  (N),
        .MB (MB),
        .LW (LW)
    ) u_unpack (
        .i_data (w_flat),
        .o_data (w_data),
        .o_len  (w_len)
    );

    // Collect bytes into slots, hold the result until taken, then drain or restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_inTake) begin
                        r_buf[r_cnt] <= in_data;
                        r_cnt        <= r_cnt + 1'b1;
                        if (!in_data[7]) begin
                            r_state <= EMIT;
                            r_err   <= w_lastSlot && w_overflow;
                        end else if (w_lastSlot) begin
                            r_state <= EMIT;
                            r_err   <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (w_outTake) begin
                        r_state <= w_overlong ? DRAIN : COLLECT;
                        r_cnt   <= '0;
                        r_buf   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (w_inTake && !in_data[7]) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                    r_cnt   <= '0;
                    r_buf   <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unpack_unsigned_stream.sv
// Scoreboard bench for the LEB128 stream decoder: directed cases with fixed
// expectations, then random byte streams decoded by an arithmetic model.
module tb_unpack_unsigned_stream;
    import unpack_unsigned_stream_pkg::*;

    localparam int N  = 64;
    localparam int MB = calcMb(N);
    localparam int LW = calcLw(N);

    typedef struct {
        logic [N-1:0]  data;
        logic [LW-1:0] len;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  out_data;
    logic [LW-1:0] out_len;
    logic          out_err;
    logic          out_valid;
    logic          out_ready;

    int   nChecks;
    int   nMiscompares;
    int   readyMode;
    bit   modelPush;
    bit   mDraining;
    logic [7:0] mCur[$];
    exp_t expQ[$];

    logic          heldValid;
    logic [N-1:0]  heldData;
    logic [LW-1:0] heldLen;
    logic          heldErr;

    unpack_unsigned_stream #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_len   (out_len),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decoder: whole values from accepted bytes using wide arithmetic.
    task automatic modelByte(input logic [7:0] b);
        logic [127:0] v;
        exp_t         e;
        bit           overlong;
        if (mDraining) begin
            if (!b[7]) mDraining = 1'b0;
            return;
        end
        mCur.push_back(b);
        if (!b[7] || mCur.size() == MB) begin
            v = '0;
            for (int i = 0; i < mCur.size(); i++)
                v = v + (128'(mCur[i] & 8'h7F) << (7 * i));
            overlong  = b[7];
            e.data    = v[N-1:0];
            e.len     = LW'(mCur.size() - 1);
            e.err     = overlong || ((v >> N) != 0);
            mDraining = overlong;
            if (modelPush) expQ.push_back(e);
            mCur.delete();
        end
    endtask

    task automatic expectOut(input logic [N-1:0] d, input int l, input logic er);
        exp_t e;
        e.data = d;
        e.len  = LW'(l);
        e.err  = er;
        expQ.push_back(e);
    endtask

    // Present one byte and keep it on the bus until it is accepted.
    task automatic applyStimulus(input logic [7:0] b);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            in_data  = b;
            in_valid = 1'b1;
            if (in_ready) begin
                modelByte(b);
                done = 1'b1;
            end
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        if (!done) begin
            nChecks++;
            nMiscompares++;
            $display("[TB] FAIL byte accept timeout: byte %h never accepted", b);
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 500 && !idle; t++) begin
            @(negedge clk);
            idle = (expQ.size() == 0) && !out_valid;
        end
        if (!idle) begin
            nChecks++;
            nMiscompares++;
            $display("[TB] FAIL drain timeout: %0d results still pending", expQ.size());
        end
    endtask

    // Consumer handshake: randomized, forced low, or forced high.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            1:       out_ready = 1'b0;
            2:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compare each taken output with the scoreboard and check holds are stable.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            heldValid = 1'b0;
        end else begin
            if (heldValid) begin
                checkOutput("hold valid", N'(out_valid), N'(1'b1));
                checkOutput("hold data", out_data, heldData);
                checkOutput("hold len", N'(out_len), N'(heldLen));
                checkOutput("hold err", N'(out_err), N'(heldErr));
            end
            if (out_valid && out_ready) begin
                heldValid = 1'b0;
                if (expQ.size() == 0) begin
                    nChecks++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpected output: data %h len %0d err %0d", out_data, out_len, out_err);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", out_data, e.data);
                    checkOutput("out_len", N'(out_len), N'(e.len));
                    checkOutput("out_err", N'(out_err), N'(e.err));
                end
            end else if (out_valid) begin
                heldValid = 1'b1;
                heldData  = out_data;
                heldLen   = out_len;
                heldErr   = out_err;
            end else begin
                heldValid = 1'b0;
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("reset in_ready", N'(in_ready), '0);
        checkOutput("reset out_valid", N'(out_valid), '0);
        checkOutput("reset out_data", out_data, '0);
        checkOutput("reset out_len", N'(out_len), '0);
        checkOutput("reset out_err", N'(out_err), '0);
    endtask

    task automatic sendRandomValue();
        int kind;
        int len;
        kind = $urandom_range(0, 9);
        if (kind == 0) begin
            for (int i = 0; i < MB; i++) applyStimulus(8'($urandom_range(0, 127)) | 8'h80);
            len = $urandom_range(0, 2);
            for (int i = 0; i < len; i++) applyStimulus(8'($urandom_range(0, 127)) | 8'h80);
            applyStimulus(8'($urandom_range(0, 127)));
        end else begin
            len = (kind == 1) ? MB : $urandom_range(1, MB);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                if (i == len - 1) applyStimulus(8'($urandom_range(0, 127)));
                else              applyStimulus(8'($urandom_range(0, 127)) | 8'h80);
            end
        end
    endtask

    initial begin
        nChecks      = 0;
        nMiscompares = 0;
        readyMode    = 2;
        modelPush    = 1'b0;
        mDraining    = 1'b0;
        heldValid    = 1'b0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        out_ready    = 1'b0;

        repeat (3) @(negedge clk);
        checkResetOutputs();
        rst = 1'b0;

        // Single zero byte, result one cycle after acceptance.
        expectOut('0, 0, 1'b0);
        applyStimulus(8'h00);
        @(negedge clk);
        checkOutput("latency out_valid", N'(out_valid), N'(1'b1));
        waitIdle();

        // Three-byte value.
        expectOut(N'(624485), 2, 1'b0);
        applyStimulus(8'hE5);
        applyStimulus(8'h8E);
        applyStimulus(8'h26);
        waitIdle();

        // Maximum length: exact fit, then overflow into weight 2^64.
        expectOut({N{1'b1}}, 9, 1'b0);
        repeat (9) applyStimulus(8'hFF);
        applyStimulus(8'h01);
        expectOut({N{1'b1}}, 9, 1'b1);
        repeat (9) applyStimulus(8'hFF);
        applyStimulus(8'h03);
        waitIdle();

        // Overlong run, drained tail, then a fresh value.
        expectOut('0, 9, 1'b1);
        expectOut(N'(5), 0, 1'b0);
        repeat (10) applyStimulus(8'h80);
        applyStimulus(8'h80);
        applyStimulus(8'h00);
        applyStimulus(8'h05);
        waitIdle();

        // Backpressure: five stalled EMIT cycles, taken on the sixth.
        readyMode = 1;
        @(posedge clk);
        expectOut(N'(8'h7F), 0, 1'b0);
        applyStimulus(8'h7F);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall in_ready", N'(in_ready), '0);
            checkOutput("stall out_data", out_data, N'(8'h7F));
        end
        readyMode = 2;
        @(negedge clk);
        @(negedge clk);
        checkOutput("after take in_ready", N'(in_ready), N'(1'b1));
        checkOutput("after take out_valid", N'(out_valid), '0);
        expectOut(N'(1), 0, 1'b0);
        applyStimulus(8'h01);
        waitIdle();

        // Reset in the middle of a value.
        applyStimulus(8'h81);
        applyStimulus(8'h82);
        @(negedge clk);
        rst = 1'b1;
        mCur.delete();
        mDraining = 1'b0;
        @(negedge clk);
        checkResetOutputs();
        rst = 1'b0;
        expectOut(N'(3), 0, 1'b0);
        applyStimulus(8'h03);
        waitIdle();

        // Random streams against the arithmetic model with random backpressure.
        modelPush = 1'b1;
        readyMode = 0;
        for (int v = 0; v < 300; v++) sendRandomValue();
        waitIdle();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nMiscompares);
        $finish;
    end

endmodule
